// File: rtl/bus_pkg.sv
// Shared definitions for the register-bus initiator: bus widths, ASCII
// protocol characters and the packet parser state encoding.
package bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_W  = 8'h57;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    TERM
  } parser_state_t;

  function automatic logic is_term(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF);
  endfunction

  function automatic logic is_start(input logic [7:0] b);
    return (b == CHAR_R) || (b == CHAR_W);
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f' map to a
// nibble with is_hex set; anything else gives nibble 0 and is_hex clear.
module hex_ascii_decode (
  input  logic [7:0] i_byte,
  output logic [3:0] o_nibble,
  output logic       o_is_hex
);

  always_comb begin
    o_nibble = 4'd0;
    o_is_hex = 1'b0;
    if (i_byte >= 8'h30 && i_byte <= 8'h39) begin
      o_nibble = i_byte[3:0];
      o_is_hex = 1'b1;
    end else if ((i_byte >= 8'h41 && i_byte <= 8'h46) ||
                 (i_byte >= 8'h61 && i_byte <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
      o_nibble = i_byte[3:0] + 4'd9;
      o_is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/bus_request_parser.sv
// Parses ASCII 'R aaaa' / 'W aaaa dddd' packets from the UART byte stream and
// issues one register-bus transaction per well-formed packet.
module bus_request_parser
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rw_o,
  output logic              valid_o,
  output logic              error_o
);

  localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

  parser_state_t     r_state, w_state_next;
  logic [1:0]        r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr_sh, w_addr_sh_next;
  logic [DATA_W-1:0] r_data_sh, w_data_sh_next;
  logic              r_rw_sh, w_rw_sh_next;
  logic [TO_W-1:0]   r_to, w_to_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic              r_rw, w_rw_next;
  logic              r_valid, w_valid_next;
  logic              r_error, w_error_next;

  logic [3:0]        w_nib;
  logic              w_is_hex;
  logic              w_bad;

  hex_ascii_decode u_hex (
    .i_byte   (rx_data_i),
    .o_nibble (w_nib),
    .o_is_hex (w_is_hex)
  );

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_addr_sh_next = r_addr_sh;
    w_data_sh_next = r_data_sh;
    w_rw_sh_next   = r_rw_sh;
    w_to_next      = r_to;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_rw_next      = r_rw;
    w_valid_next   = 1'b0;
    w_error_next   = 1'b0;
    w_bad          = 1'b0;

    if (rx_valid_i) begin
      w_to_next = '0;
      unique case (r_state)
        IDLE: begin
          if (is_start(rx_data_i)) begin
            w_rw_sh_next = (rx_data_i == CHAR_W);
            w_state_next = ADDR;
            w_cnt_next   = 2'd0;
          end
        end
        ADDR: begin
          if (w_is_hex) begin
            w_addr_sh_next = {r_addr_sh[ADDR_W-5:0], w_nib};
            if (r_cnt == 2'd3) begin
              w_cnt_next   = 2'd0;
              w_state_next = r_rw_sh ? DATA : TERM;
            end else begin
              w_cnt_next = r_cnt + 2'd1;
            end
          end else begin
            w_bad = 1'b1;
          end
        end
        DATA: begin
          if (w_is_hex) begin
            w_data_sh_next = {r_data_sh[DATA_W-5:0], w_nib};
            if (r_cnt == 2'd3) begin
              w_cnt_next   = 2'd0;
              w_state_next = TERM;
            end else begin
              w_cnt_next = r_cnt + 2'd1;
            end
          end else begin
            w_bad = 1'b1;
          end
        end
        TERM: begin
          if (is_term(rx_data_i)) begin
            w_valid_next = 1'b1;
            w_addr_next  = r_addr_sh;
            w_rw_next    = r_rw_sh;
            // Reads leave the last write data in place.
            w_wdata_next = r_rw_sh ? r_data_sh : r_wdata;
            w_state_next = IDLE;
          end else begin
            w_bad = 1'b1;
          end
        end
        default: w_state_next = IDLE;
      endcase

      // A start character inside a packet resynchronises onto a fresh packet.
      if (w_bad) begin
        w_error_next = 1'b1;
        w_cnt_next   = 2'd0;
        if (is_start(rx_data_i)) begin
          w_rw_sh_next = (rx_data_i == CHAR_W);
          w_state_next = ADDR;
        end else begin
          w_state_next = IDLE;
        end
      end
    end else if (TIMEOUT_CYCLES > 0 && r_state != IDLE) begin
      if (r_to == TO_LAST) begin
        w_error_next = 1'b1;
        w_state_next = IDLE;
        w_cnt_next   = 2'd0;
        w_to_next    = '0;
      end else begin
        w_to_next = r_to + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_rw_sh   <= 1'b0;
      r_to      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_addr_sh <= w_addr_sh_next;
      r_data_sh <= w_data_sh_next;
      r_rw_sh   <= w_rw_sh_next;
      r_to      <= w_to_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_rw      <= w_rw_next;
      r_valid   <= w_valid_next;
      r_error   <= w_error_next;
    end
  end

  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;
  assign rdata_o = '0;
  assign rw_o    = r_rw;
  assign valid_o = r_valid;
  assign error_o = r_error;

endmodule

// File: tb/tb_bus_request_parser.sv
// Directed bench: two parser instances (timeout disabled and TIMEOUT_CYCLES=8)
// driven by one byte stream; packet table plus hand-written timing sequences.
module tb_bus_request_parser;
  import bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic [15:0] addr0, wdata0, rdata0, addr8, wdata8, rdata8;
  logic        rw0, valid0, err0, rw8, valid8, err8;

  bus_request_parser #(.TIMEOUT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .addr_o(addr0), .wdata_o(wdata0), .rdata_o(rdata0), .rw_o(rw0),
    .valid_o(valid0), .error_o(err0)
  );

  bus_request_parser #(.TIMEOUT_CYCLES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .addr_o(addr8), .wdata_o(wdata8), .rdata_o(rdata8), .rw_o(rw8),
    .valid_o(valid8), .error_o(err8)
  );

  int checks = 0;
  int errors = 0;
  int v0_cnt = 0, e0_cnt = 0, v8_cnt = 0, e8_cnt = 0;
  int overlap0 = 0, overlap8 = 0;

  always @(negedge clk) begin
    if (valid0) v0_cnt <= v0_cnt + 1;
    if (err0)   e0_cnt <= e0_cnt + 1;
    if (valid8) v8_cnt <= v8_cnt + 1;
    if (err8)   e8_cnt <= e8_cnt + 1;
    if (valid0 && err0) overlap0 <= overlap0 + 1;
    if (valid8 && err8) overlap8 <= overlap8 + 1;
  end

  typedef struct {
    string       pkt;
    int          max_gap;
    int          exp_v;
    int          exp_e;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (i < s.len() - 1 && max_gap > 0) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  int sv0, se0, sv8, se8;

  task automatic snap();
    #1;
    sv0 = v0_cnt; se0 = e0_cnt; sv8 = v8_cnt; se8 = e8_cnt;
  endtask

  initial begin
    vecs[0]  = '{"W1234beef\n",           3, 1, 0, 16'h1234, 16'hBEEF, 1'b1};
    vecs[1]  = '{"R12G4\015",             0, 0, 1, 16'h1234, 16'hBEEF, 1'b1};
    vecs[2]  = '{"R0001\015",             0, 1, 0, 16'h0001, 16'hBEEF, 1'b0};
    vecs[3]  = '{"R12W0005000A\015",      1, 1, 1, 16'h0005, 16'h000A, 1'b1};
    vecs[4]  = '{"R123\015",              0, 0, 1, 16'h0005, 16'h000A, 1'b1};
    vecs[5]  = '{"\015\nxyz09",           0, 0, 0, 16'h0005, 16'h000A, 1'b1};
    vecs[6]  = '{"WFFFF0000\015",         2, 1, 0, 16'hFFFF, 16'h0000, 1'b1};
    vecs[7]  = '{"R0W\015",               0, 0, 2, 16'hFFFF, 16'h0000, 1'b1};
    vecs[8]  = '{"W00000000R\015",        0, 0, 2, 16'hFFFF, 16'h0000, 1'b1};
    vecs[9]  = '{"Wabcd12345\015",        0, 0, 1, 16'hFFFF, 16'h0000, 1'b1};
    vecs[10] = '{"RaBcD\n",               0, 1, 0, 16'hABCD, 16'h0000, 1'b0};

    // Reset state
    rst_n = 1'b0;
    idle(3);
    chk("rst_addr0",  addr0,  0);
    chk("rst_wdata0", wdata0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rw0",    rw0,    0);
    chk("rst_valid0", valid0, 0);
    chk("rst_err0",   err0,   0);
    chk("rst_addr8",  addr8,  0);
    chk("rst_err8",   err8,   0);
    rst_n = 1'b1;
    idle(2);

    // Read latency: valid exactly one cycle after the terminator edge
    send_str("R0A1F", 0);
    chk("a_pre_valid0", valid0, 0);
    send_byte(CHAR_CR);
    chk("a_valid0", valid0, 1);
    chk("a_valid8", valid8, 1);
    chk("a_addr0",  addr0,  16'h0A1F);
    chk("a_rw0",    rw0,    0);
    chk("a_rdata0", rdata0, 0);
    chk("a_err0",   err0,   0);
    idle(1);
    chk("a_oneshot0", valid0, 0);
    idle(2);

    // Error timing: pulse one cycle after the bad byte, for one cycle
    send_str("R12", 0);
    chk("b_pre_err0", err0, 0);
    send_str("G", 0);
    chk("b_err0",   err0,   1);
    chk("b_err8",   err8,   1);
    chk("b_valid0", valid0, 0);
    idle(1);
    chk("b_oneshot0", err0, 0);
    idle(2);

    // Packet table
    for (int i = 0; i < 11; i++) begin
      snap();
      send_str(vecs[i].pkt, vecs[i].max_gap);
      idle(2);
      #1;
      chk($sformatf("v%0d_nvalid0", i), v0_cnt - sv0, vecs[i].exp_v);
      chk($sformatf("v%0d_nerr0", i),   e0_cnt - se0, vecs[i].exp_e);
      chk($sformatf("v%0d_nvalid8", i), v8_cnt - sv8, vecs[i].exp_v);
      chk($sformatf("v%0d_nerr8", i),   e8_cnt - se8, vecs[i].exp_e);
      chk($sformatf("v%0d_addr0", i),   addr0,  vecs[i].addr);
      chk($sformatf("v%0d_wdata0", i),  wdata0, vecs[i].wdata);
      chk($sformatf("v%0d_rw0", i),     rw0,    vecs[i].rw);
      chk($sformatf("v%0d_rdata0", i),  rdata0, 0);
      chk($sformatf("v%0d_addr8", i),   addr8,  vecs[i].addr);
      $display("vec %0d pkt_len=%0d addr=%h wdata=%h rw=%0d", i, vecs[i].pkt.len(), addr0, wdata0, rw0);
    end

    // Reset mid-packet
    send_str("W00", 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("d_addr0",  addr0,  0);
    chk("d_wdata0", wdata0, 0);
    chk("d_rw0",    rw0,    0);
    chk("d_valid0", valid0, 0);
    chk("d_err0",   err0,   0);
    chk("d_addr8",  addr8,  0);
    snap();
    send_str("AB\015", 0);
    idle(2);
    #1;
    chk("d_frag_nvalid0", v0_cnt - sv0, 0);
    chk("d_frag_nerr0",   e0_cnt - se0, 0);
    snap();
    send_str("R0002\015", 0);
    idle(2);
    #1;
    chk("d_nvalid0", v0_cnt - sv0, 1);
    chk("d_addr0b",  addr0, 16'h0002);
    chk("d_rw0b",    rw0,   0);

    // Timeout: 8 idle cycles abort on the TIMEOUT_CYCLES=8 instance only
    snap();
    send_str("R12", 0);
    idle(7);
    chk("e_err8_c7", err8, 0);
    idle(1);
    chk("e_err8_c8",   err8,   1);
    chk("e_valid8_c8", valid8, 0);
    idle(12);
    #1;
    chk("e_nerr8",       e8_cnt - se8, 1);
    chk("e_nerr0_nott",  e0_cnt - se0, 0);
    send_byte(CHAR_CR);
    idle(2);
    snap();
    send_str("R12", 0);
    idle(7);
    send_str("3F\015", 0);
    chk("e_late_valid8", valid8, 1);
    chk("e_late_addr8",  addr8,  16'h123F);
    idle(2);
    #1;
    chk("e_late_nerr8", e8_cnt - se8, 0);
    snap();
    send_str("R00FF\015", 0);
    idle(2);
    #1;
    chk("e_nvalid8", v8_cnt - sv8, 1);
    chk("e_nerr8b",  e8_cnt - se8, 0);
    chk("e_addr8",   addr8, 16'h00FF);
    chk("e_addr0",   addr0, 16'h00FF);

    chk("overlap0", overlap0, 0);
    chk("overlap8", overlap8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_request_parser.md
Name: bus_request_parser

Overview:
- Initiator end of the daisy-chained register bus (addr/wdata/rdata/rw/valid) that the analyzer cores respond on.
- Consumes a byte stream from the UART receiver and parses ASCII request packets.
- Emits one bus transaction per well-formed packet into the head of the core chain.
- Malformed packets are dropped and flagged; partial packets can time out.

Parameters:
- TIMEOUT_CYCLES, 0: idle cycles allowed between bytes inside a packet before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- rx_data_i  input  8  received byte
- rx_valid_i  input  1  rx_data_i valid this cycle; bytes may arrive every cycle
- addr_o  output  16  bus address
- wdata_o  output  16  bus write data
- rdata_o  output  16  bus read data; always 0 (responding cores fill it)
- rw_o  output  1  0 = read, 1 = write
- valid_o  output  1  one-cycle transaction strobe
- error_o  output  1  one-cycle pulse when a packet is dropped

Behaviour:
- Packet formats:
  - Read: 'R' (0x52), 4 hex digits of address, terminator.
  - Write: 'W' (0x57), 4 hex digits of address, 4 hex digits of data, terminator.
  - Terminator is CR (0x0D) or LF (0x0A).
  - Hex digits are 0-9, A-F, a-f, most-significant nibble first.
- Reset (rst_n=0 at a clk edge): all outputs 0, state IDLE, nibble counter 0, timeout counter 0, any partial packet discarded.
- States:
  - IDLE: 'R' or 'W' latches rw and goes to ADDR with the counter cleared. Every other byte, including CR/LF, is ignored silently with no error.
  - ADDR: each hex digit shifts into the address register. After the 4th digit, go to TERM for reads or DATA for writes.
  - DATA: each hex digit shifts into the data register. After the 4th digit, go to TERM.
  - TERM: CR or LF completes the packet and returns to IDLE.
- Bad bytes in ADDR/DATA/TERM:
  - 'R' or 'W': error_o pulses and the parser resyncs, starting a new packet of that type. This means the state stays in or re-enters ADDR with the counter cleared.
  - Any other unexpected byte (non-hex in ADDR/DATA, non-terminator in TERM, early terminator): error_o pulses and the state returns to IDLE.
- Latency: the terminator accepted at edge N gives valid_o=1 in the cycle after edge N, for exactly one cycle.
- Output holding: addr_o, wdata_o and rw_o update at that same edge and then hold until the next completed packet.
- wdata_o on a read: holds its previous value, and must be ignored by cores.
- Registers written during parsing are internal shadows; they must not disturb addr_o/wdata_o/rw_o until completion.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments on each cycle in a non-IDLE state with rx_valid_i=0, and clears on any accepted byte.
  - When it reaches TIMEOUT_CYCLES, error_o pulses, the state goes to IDLE and the counter clears.
  - If a byte arrives in the same cycle, the byte wins and no timeout occurs.
- Error strobe: error_o and valid_o are never high in the same cycle. error_o is registered, one cycle after the offending byte.
- rx_valid_i=0 with no timeout pending: state holds.

Decomposition:
- Shared package (bus_pkg):
  - Bus widths: ADDR_W=16, DATA_W=16.
  - ASCII constants: CHAR_R, CHAR_W, CHAR_CR, CHAR_LF.
  - Parser state enum: IDLE, ADDR, DATA, TERM.
- Natural sub-module: hex_ascii_decode. Combinational; byte in, 4-bit nibble plus is_hex flag out. Reusable by the response formatter on the transmit side.

Test Plan:
- Read: bytes "R0A1F\r" back-to-back -> exactly one valid_o pulse one cycle after CR; addr_o=0x0A1F, rw_o=0, rdata_o=0, error_o never high.
- Write, lowercase, mixed gaps: "W1234beef\n" with random 0-3 idle cycles between bytes (TIMEOUT_CYCLES=0) -> one valid_o; addr_o=0x1234, wdata_o=0xBEEF, rw_o=1; outputs hold afterwards.
- Malformed address: "R12G4\r" -> error_o pulse one cycle after 'G', no valid_o. Then "R0001\r" -> valid_o, addr_o=0x0001.
- Resync: "R12W0005000A\r" -> error_o pulse after 'W', then one valid_o with addr_o=0x0005, wdata_o=0x000A, rw_o=1. Also "R123\r" (early terminator) -> error_o, no valid_o.
- Timeout with TIMEOUT_CYCLES=8: "R12" then 8 idle cycles -> error_o pulse, state IDLE. A byte arriving on cycle 8 -> no error. Following "R00FF\r" -> addr_o=0x00FF.
- Reset mid-packet: "W00" then rst_n=0 for one cycle, then "AB\r" and "R0002\r" -> all outputs 0 after reset; no transaction and no error from the "AB\r" fragment (ignored in IDLE); one read with addr_o=0x0002.
